// File: rtl/sccomp_run_ctrl.sv
// Run controller for the single-cycle CPU: sequences CPU reset, gates execution
// with a clock enable (free-run or single-step) and captures {pc,inst} traces.
module sccomp_run_ctrl #(
  parameter int WIDTH         = 32,
  parameter int TRACE_DEPTH   = 16,
  parameter int RST_HOLD      = 2,
  parameter int CNT_W         = 16,
  parameter int STALL_ON_FULL = 1
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic [CNT_W-1:0]     max_cycles,
  input  logic [WIDTH-1:0]     pc,
  input  logic [WIDTH-1:0]     inst,
  output logic                 cpu_clrn,
  output logic                 cpu_en,
  output logic                 running,
  output logic                 done,
  output logic [CNT_W-1:0]     cycle_cnt,
  input  logic                 tr_rd,
  output logic [2*WIDTH-1:0]   tr_data,
  output logic                 tr_empty,
  output logic                 tr_full,
  output logic                 tr_ovf
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int HW = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_STEP, S_DONE} state_t;

  state_t               state, state_nx;
  logic [HW-1:0]        hold_cnt;
  logic                 mode_q;
  logic [CNT_W-1:0]     max_q;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 at_max;
  logic                 restart;
  logic                 stall;
  logic                 push_ok;
  logic                 pop;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [2*WIDTH-1:0]   mem [TRACE_DEPTH];

  assign tr_empty = (wr_ptr == rd_ptr);
  assign tr_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign stall    = (STALL_ON_FULL != 0) && tr_full && !tr_rd;
  assign push_ok  = cpu_en && (!tr_full || tr_rd);
  assign pop      = tr_rd && !tr_empty;
  assign tr_data  = tr_empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign cnt_inc  = cycle_cnt + CNT_W'(1);
  assign at_max   = (max_q != '0) && (cnt_inc == max_q);
  // A start while the CPU is already being reset is ignored; abort always wins.
  assign restart  = start && !abort && (state != S_RESET);

  always_comb begin
    state_nx = state;
    cpu_en   = 1'b0;
    running  = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_RESET;
      S_RESET: if (hold_cnt == HW'(1)) state_nx = mode_q ? S_STEP : S_RUN;
      S_RUN: begin
        running = 1'b1;
        cpu_en  = !stall;
        if (cpu_en && at_max) state_nx = S_DONE;
      end
      S_STEP: begin
        running = 1'b1;
        cpu_en  = step && !stall;
        if (cpu_en && at_max) state_nx = S_DONE;
      end
      S_DONE:  done = 1'b1;
      default: state_nx = S_IDLE;
    endcase
    if (restart) state_nx = S_RESET;
    if (abort)   state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= S_IDLE;
      cpu_clrn  <= 1'b0;
      hold_cnt  <= '0;
      mode_q    <= 1'b0;
      max_q     <= '0;
      cycle_cnt <= '0;
      tr_ovf    <= 1'b0;
    end else begin
      state    <= state_nx;
      // CPU stays out of reset through DONE so its state can be inspected.
      cpu_clrn <= (state_nx == S_RUN) || (state_nx == S_STEP) || (state_nx == S_DONE);
      if (state == S_RESET) hold_cnt <= hold_cnt - HW'(1);
      if (cpu_en && !push_ok) tr_ovf <= 1'b1;
      if (cpu_en && (cycle_cnt != '1)) cycle_cnt <= cnt_inc;
      if (restart) begin
        hold_cnt  <= HW'(RST_HOLD);
        mode_q    <= step_mode;
        max_q     <= max_cycles;
        cycle_cnt <= '0;
        tr_ovf    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {pc, inst};
  end

endmodule
